fb_write_ctrl: RTL and testbench

FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

---
 rtl/fb_write_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_fb_write_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// Wishbone-controlled frame-buffer writer: single pixel writes plus a rectangular-free
// linear fill engine driving one registered memory write port.
module fb_write_ctrl #(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned PIX_W     = 4,
  parameter int unsigned FB_PIXELS = 307200
) (
  input  logic              clk,
  input  logic              wb_rst_n,
  input  logic [2:0]        wb_m2s_fb_adr,
  input  logic [31:0]       wb_m2s_fb_dat,
  input  logic              wb_m2s_fb_we,
  input  logic              wb_m2s_fb_stb,
  input  logic              wb_m2s_fb_cyc,
  output logic [31:0]       wb_s2m_fb_dat,
  output logic              wb_s2m_fb_ack,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [PIX_W-1:0]  mem_dina,
  output logic              mem_wea,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StFill = 1'b1;

  localparam logic [2:0] AdrCtrl  = 3'd0;
  localparam logic [2:0] AdrBase  = 3'd1;
  localparam logic [2:0] AdrLen   = 3'd2;
  localparam logic [2:0] AdrColor = 3'd3;
  localparam logic [2:0] AdrPixel = 3'd4;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FB_PIXELS - 1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

  logic [0:0]        state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       rd_dat_q, rd_dat_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic [31:0]       pix_word_q, pix_word_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              done_q, done_d;

  logic              busy;
  logic              accept;
  logic              wr_acc;
  logic              pix_wr;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_ok;
  logic [31:0]       rd_mux;

  assign busy     = (state_q == StFill);
  assign accept   = wb_m2s_fb_stb & wb_m2s_fb_cyc & ~ack_q;
  assign wr_acc   = accept & wb_m2s_fb_we;
  assign pix_wr   = wr_acc && (wb_m2s_fb_adr == AdrPixel);
  assign pix_addr = wb_m2s_fb_dat[ADDR_W+3:4];
  assign pix_ok   = (32'(pix_addr) < FB_PIXELS);

  always_comb begin
    rd_mux = '0;
    case (wb_m2s_fb_adr)
      AdrCtrl:  rd_mux = {30'b0, err_q, busy};
      AdrBase:  rd_mux = 32'(base_q);
      AdrLen:   rd_mux = 32'(len_q);
      AdrColor: rd_mux = 32'(color_q);
      AdrPixel: rd_mux = pix_word_q;
      default:  rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = accept;
    rd_dat_d    = rd_dat_q;
    err_d       = err_q;
    base_d      = base_q;
    len_d       = len_q;
    color_d     = color_q;
    pix_word_d  = pix_word_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    done_d      = 1'b0;

    if (accept) begin
      rd_dat_d = rd_mux;
    end

    if (wr_acc) begin
      case (wb_m2s_fb_adr)
        AdrCtrl: begin
          // Clear is applied first so a rejected start in the same write still flags err.
          if (wb_m2s_fb_dat[1]) err_d = 1'b0;
          if (wb_m2s_fb_dat[0]) begin
            if (busy) begin
              err_d = 1'b1;
            end else if (len_q == '0) begin
              done_d = 1'b1;
            end else begin
              state_d     = StFill;
              cur_addr_d  = base_q;
              remaining_d = len_q;
            end
          end
        end
        AdrBase: begin
          if (busy) err_d = 1'b1;
          else      base_d = wb_m2s_fb_dat[ADDR_W-1:0];
        end
        AdrLen: begin
          if (busy) err_d = 1'b1;
          else      len_d = wb_m2s_fb_dat[ADDR_W-1:0];
        end
        AdrColor: begin
          if (busy) err_d = 1'b1;
          else      color_d = wb_m2s_fb_dat[PIX_W-1:0];
        end
        AdrPixel: begin
          pix_word_d = wb_m2s_fb_dat;
          if (pix_ok) begin
            mem_we_d   = 1'b1;
            mem_addr_d = pix_addr;
            mem_din_d  = wb_m2s_fb_dat[PIX_W-1:0];
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Host pixel writes own the port; the fill simply holds its position that cycle.
    if (busy && !pix_wr) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cur_addr_q;
      mem_din_d   = color_q;
      cur_addr_d  = (cur_addr_q == LastAddr) ? '0 : cur_addr_q + AddrOne;
      remaining_d = remaining_q - AddrOne;
      if (remaining_q == AddrOne) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q     <= StIdle;
      ack_q       <= 1'b0;
      rd_dat_q    <= '0;
      err_q       <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      color_q     <= '0;
      pix_word_q  <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      rd_dat_q    <= rd_dat_d;
      err_q       <= err_d;
      base_q      <= base_d;
      len_q       <= len_d;
      color_q     <= color_d;
      pix_word_q  <= pix_word_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      done_q      <= done_d;
    end
  end

  assign wb_s2m_fb_dat = rd_dat_q;
  assign wb_s2m_fb_ack = ack_q;
  assign mem_addra     = mem_addr_q;
  assign mem_dina      = mem_din_q;
  assign mem_wea       = mem_we_q;
  assign fill_busy     = busy;
  assign fill_done     = done_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl: register access, pixel writes, fills, wrap, priority,
// error flagging and asynchronous reset abort.
module tb_fb_write_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  adr;
  logic [31:0] dat;
  logic        we, stb, cyc;
  logic [31:0] s2m_dat;
  logic        ack;
  logic [18:0] mem_addra;
  logic [3:0]  mem_dina;
  logic        mem_wea;
  logic        fill_busy;
  logic        fill_done;

  fb_write_ctrl dut (
    .clk           (clk),
    .wb_rst_n      (rst_n),
    .wb_m2s_fb_adr (adr),
    .wb_m2s_fb_dat (dat),
    .wb_m2s_fb_we  (we),
    .wb_m2s_fb_stb (stb),
    .wb_m2s_fb_cyc (cyc),
    .wb_s2m_fb_dat (s2m_dat),
    .wb_s2m_fb_ack (ack),
    .mem_addra     (mem_addra),
    .mem_dina      (mem_dina),
    .mem_wea       (mem_wea),
    .fill_busy     (fill_busy),
    .fill_done     (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  din;
    logic [31:0] cyc;
  } wr_rec_t;

  wr_rec_t     wlog[$];
  logic [31:0] cyc_cnt  = 0;
  int          done_cnt = 0;
  int          n_cmp    = 0;
  int          n_bad    = 0;

  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_wea) wlog.push_back({32'(mem_addra), mem_dina, cyc_cnt});
    if (fill_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic w, input logic [2:0] a,
                      input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d;
    @(posedge clk);
    #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    @(negedge clk);
    rd = s2m_dat;
    check({tag, "_ack"}, 32'(ack), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (fill_done) seen = 1'b1;
    end
    if (!seen) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  int          n_at;

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_wea", 32'(mem_wea), 32'd0);
    check("rst_addr", 32'(mem_addra), 32'd0);
    check("rst_dina", 32'(mem_dina), 32'd0);
    check("rst_busy", 32'(fill_busy), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    check("rst_rdat", s2m_dat, 32'd0);
    rst_n = 1'b1;

    // Single pixel write: one-cycle latency, one cycle wide.
    xfer("pix", 1'b1, 3'd4, 32'h0000_1235, rd);
    check("pix_wea", 32'(mem_wea), 32'd1);
    check("pix_addr", 32'(mem_addra), 32'h123);
    check("pix_dina", 32'(mem_dina), 32'h5);
    @(negedge clk);
    check("pix_wea_drop", 32'(mem_wea), 32'd0);
    check("pix_ack_drop", 32'(ack), 32'd0);
    check("pix_addr_hold", 32'(mem_addra), 32'h123);
    xfer("pix_rd", 1'b0, 3'd4, 32'd0, rd);
    check("pix_rd_val", rd, 32'h0000_1235);

    // Register readback with upper bits masked; unmapped address.
    xfer("wb", 1'b1, 3'd1, 32'hFFF8_0064, rd);
    xfer("wl", 1'b1, 3'd2, 32'd4, rd);
    xfer("wc", 1'b1, 3'd3, 32'hFFFF_FFFA, rd);
    xfer("rb", 1'b0, 3'd1, 32'd0, rd);
    check("base_rd", rd, 32'd100);
    xfer("rl", 1'b0, 3'd2, 32'd0, rd);
    check("len_rd", rd, 32'd4);
    xfer("rc", 1'b0, 3'd3, 32'd0, rd);
    check("color_rd", rd, 32'hA);
    xfer("w5", 1'b1, 3'd5, 32'hDEAD_BEEF, rd);
    xfer("r5", 1'b0, 3'd5, 32'd0, rd);
    check("unmapped_rd", rd, 32'd0);

    // Basic fill 100..103 colour A.
    wlog.delete();
    n_at = done_cnt;
    xfer("start1", 1'b1, 3'd0, 32'd1, rd);
    check("fill1_busy", 32'(fill_busy), 32'd1);
    wait_done("fill1");
    check("fill1_done_addr", 32'(mem_addra), 32'd103);
    check("fill1_done_wea", 32'(mem_wea), 32'd1);
    @(negedge clk);
    check("fill1_busy_after", 32'(fill_busy), 32'd0);
    check("fill1_done_pulse", 32'(fill_done), 32'd0);
    check("fill1_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < wlog.size(); i++) begin
      check("fill1_addr", wlog[i].addr, 32'(100 + i));
      check("fill1_din", 32'(wlog[i].din), 32'hA);
      check("fill1_consec", wlog[i].cyc - wlog[0].cyc, 32'(i));
    end
    check("fill1_done_cnt", 32'(done_cnt - n_at), 32'd1);

    // Zero-length start: done in ack cycle, no writes.
    xfer("wl0", 1'b1, 3'd2, 32'd0, rd);
    wlog.delete();
    xfer("start0", 1'b1, 3'd0, 32'd1, rd);
    check("len0_done", 32'(fill_done), 32'd1);
    check("len0_busy", 32'(fill_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("len0_nowrites", 32'(wlog.size()), 32'd0);

    // Wrap at end of frame buffer.
    xfer("wb2", 1'b1, 3'd1, 32'd307198, rd);
    xfer("wl2", 1'b1, 3'd2, 32'd3, rd);
    wlog.delete();
    xfer("start2", 1'b1, 3'd0, 32'd1, rd);
    wait_done("wrap");
    @(negedge clk);
    check("wrap_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      check("wrap_a0", wlog[0].addr, 32'd307198);
      check("wrap_a1", wlog[1].addr, 32'd307199);
      check("wrap_a2", wlog[2].addr, 32'd0);
    end

    // Pixel write to 7 (colour 3) during a fill of 0..7.
    xfer("wb3", 1'b1, 3'd1, 32'd0, rd);
    xfer("wl3", 1'b1, 3'd2, 32'd8, rd);
    wlog.delete();
    xfer("start3", 1'b1, 3'd0, 32'd1, rd);
    xfer("pix3", 1'b1, 3'd4, 32'h0000_0073, rd);
    wait_done("prio");
    @(negedge clk);
    check("prio_count", 32'(wlog.size()), 32'd9);
    if (wlog.size() == 9) begin
      check("prio_span", wlog[8].cyc - wlog[0].cyc, 32'd8);
      for (int a = 0; a < 8; a++) begin
        int hits;
        hits = 0;
        for (int i = 0; i < 9; i++)
          if (wlog[i].addr == 32'(a) && wlog[i].din == 4'hA) hits++;
        check("prio_fill_once", 32'(hits), 32'd1);
      end
      n_at = 0;
      for (int i = 0; i < 9; i++)
        if (wlog[i].addr == 32'd7 && wlog[i].din == 4'h3) n_at++;
      check("prio_pixel", 32'(n_at), 32'd1);
    end

    // Errors: start, base write and out-of-range pixel during fill.
    xfer("wb4", 1'b1, 3'd1, 32'd0, rd);
    xfer("wl4", 1'b1, 3'd2, 32'd6, rd);
    xfer("wc4", 1'b1, 3'd3, 32'd5, rd);
    wlog.delete();
    xfer("start4", 1'b1, 3'd0, 32'd1, rd);
    xfer("restart4", 1'b1, 3'd0, 32'd1, rd);
    xfer("oob4", 1'b1, 3'd4, (32'd400000 << 4) | 32'd1, rd);
    xfer("bbusy4", 1'b1, 3'd1, 32'd77, rd);
    wait_done("err");
    @(negedge clk);
    check("err_count", 32'(wlog.size()), 32'd6);
    for (int i = 0; i < wlog.size(); i++) begin
      check("err_addr", wlog[i].addr, 32'(i));
      check("err_din", 32'(wlog[i].din), 32'h5);
    end
    xfer("ctrl_rd", 1'b0, 3'd0, 32'd0, rd);
    check("err_set", rd, 32'h2);
    xfer("base_rd2", 1'b0, 3'd1, 32'd0, rd);
    check("base_ignored", rd, 32'd0);
    xfer("clr", 1'b1, 3'd0, 32'h2, rd);
    xfer("ctrl_rd2", 1'b0, 3'd0, 32'd0, rd);
    check("err_clr", rd, 32'h0);

    // Reset mid-fill.
    xfer("wl5", 1'b1, 3'd2, 32'd1000, rd);
    xfer("start5", 1'b1, 3'd0, 32'd1, rd);
    repeat (20) @(negedge clk);
    n_at = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wea", 32'(mem_wea), 32'd0);
    check("arst_addr", 32'(mem_addra), 32'd0);
    check("arst_dina", 32'(mem_dina), 32'd0);
    check("arst_busy", 32'(fill_busy), 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    wlog.delete();
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("arst_nowrites", 32'(wlog.size()), 32'd0);
    check("arst_nodone", 32'(done_cnt - n_at), 32'd0);
    xfer("ctrl_rd3", 1'b0, 3'd0, 32'd0, rd);
    check("arst_ctrl", rd, 32'd0);
    xfer("len_rd3", 1'b0, 3'd2, 32'd0, rd);
    check("arst_len", rd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
